// File: rtl/ddf_pkg.sv
// Shared types and width helpers for the theme controller.
package ddf_pkg;

  // User theme mode as presented on mode_i.
  typedef enum logic [1:0] {
    MODE_AUTO   = 2'd0,
    MODE_DARK   = 2'd1,
    MODE_LIGHT  = 2'd2,
    MODE_BYPASS = 2'd3
  } mode_t;

  // Frame tracker: SYNC until the first vs edge, then ACTIVE.
  typedef enum logic {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } tracker_state_t;

  localparam int DEF_HBLKS = 10;
  localparam int DEF_VBLKS = 10;

  // Bits needed to index 0..n-1, never less than one.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_HT_W  = width_of(DEF_HBLKS);
  localparam int DEF_VT_W  = width_of(DEF_VBLKS);
  localparam int DEF_CNT_W = width_of(DEF_HBLKS * DEF_VBLKS + 1);

endpackage

// File: rtl/theme_ctrl_blk_locator.sv
// Block locator: timing edge detection, pixel/block counters, geometry
// check and the frame-close strobe for theme_ctrl.
module blk_locator
  import ddf_pkg::*;
#(
  parameter int HBLKS = 10,
  parameter int VBLKS = 10,
  parameter int HRES  = 1920,
  parameter int VRES  = 1080,
  localparam int HT_W = width_of(HBLKS),
  localparam int VT_W = width_of(VBLKS)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            vin_vs_i,
  input  logic            vin_hs_i,
  input  logic            vin_de_i,
  output logic [HT_W-1:0] ht_cur_o,
  output logic [VT_W-1:0] vt_cur_o,
  output logic            origin_o,
  output logic            vs_rise_o,
  output logic            frame_close_o,
  output logic            frame_bad_o
);

  localparam int BW = HRES / HBLKS;
  localparam int BH = VRES / VBLKS;
  localparam int XW = width_of(HRES);
  localparam int YW = width_of(VRES);

  tracker_state_t  state_q, state_d;
  logic            vs_q, hs_q, de_q;
  logic [XW-1:0]   x_q, x_d, bx_q, bx_d;
  logic [HT_W-1:0] ht_q, ht_d, ht_cur_q, ht_cur_d;
  logic            hfull_q, hfull_d;
  logic [YW-1:0]   y_q, y_d, by_q, by_d;
  logic [VT_W-1:0] vt_q, vt_d, vt_cur_q, vt_cur_d;
  logic            vfull_q, vfull_d;
  logic            err_q, err_d;

  logic            vs_rise, hs_rise, de_fall;
  logic [XW-1:0]   x_base, bx_base;
  logic [HT_W-1:0] ht_base;
  logic            hfull_base;
  logic [YW-1:0]   y_base, by_base;
  logic [VT_W-1:0] vt_base;
  logic            vfull_base;

  // Edge strobes and the coordinates of the pixel on the inputs this cycle
  // (a sync edge in the same cycle clears them first).
  always_comb begin
    vs_rise    = vin_vs_i & ~vs_q;
    hs_rise    = vin_hs_i & ~hs_q;
    de_fall    = ~vin_de_i & de_q;
    x_base     = hs_rise ? '0 : x_q;
    bx_base    = hs_rise ? '0 : bx_q;
    ht_base    = hs_rise ? '0 : ht_q;
    hfull_base = hs_rise ? 1'b0 : hfull_q;
    y_base     = vs_rise ? '0 : y_q;
    by_base    = vs_rise ? '0 : by_q;
    vt_base    = vs_rise ? '0 : vt_q;
    vfull_base = vs_rise ? 1'b0 : vfull_q;
  end

  // Tracker FSM next state; frames are only closed once a full frame has started.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d       = state_q;
    frame_close_o = 1'b0;
    case (state_q)
      SYNC:   if (vs_rise) state_d = ACTIVE;
      ACTIVE: if (vs_rise) frame_close_o = 1'b1;
    endcase
  end

  // Pixel/line counters with saturation and the sticky per-frame geometry error.
  always_comb begin
    x_d     = x_base;
    bx_d    = bx_base;
    ht_d    = ht_base;
    hfull_d = hfull_base;
    y_d     = y_base;
    by_d    = by_base;
    vt_d    = vt_base;
    vfull_d = vfull_base;
    err_d   = vs_rise ? 1'b0 : err_q;

    if (vin_de_i) begin
      // hfull marks that pixel HRES-1 was seen; any further pixel means a long line.
      if (hfull_base) err_d = 1'b1;
      if (x_base == XW'(HRES - 1)) hfull_d = 1'b1;
      else                         x_d     = x_base + 1'b1;
      if (bx_base == XW'(BW - 1)) begin
        bx_d = '0;
        if (ht_base != HT_W'(HBLKS - 1)) ht_d = ht_base + 1'b1;
      end else begin
        bx_d = bx_base + 1'b1;
      end
    end

    if (de_fall) begin
      // A line that ended before pixel HRES-1, or a line beyond VRES, is bad geometry.
      if (!hfull_q || vfull_base) err_d = 1'b1;
      if (y_base == YW'(VRES - 1)) vfull_d = 1'b1;
      else                         y_d     = y_base + 1'b1;
      if (by_base == YW'(BH - 1)) begin
        by_d = '0;
        if (vt_base != VT_W'(VBLKS - 1)) vt_d = vt_base + 1'b1;
      end else begin
        by_d = by_base + 1'b1;
      end
    end

    ht_cur_d = ht_base;
    vt_cur_d = vt_base;
  end

  // Block-origin sample and frame quality presented to the accumulator.
  always_comb begin
    origin_o    = vin_de_i & (bx_base == '0) & (by_base == '0);
    vs_rise_o   = vs_rise;
    frame_bad_o = err_q | ~vfull_q;
    ht_cur_o    = ht_cur_q;
    vt_cur_o    = vt_cur_q;
  end

  // State, delay and counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      state_q  <= SYNC;
      vs_q     <= 1'b0;
      hs_q     <= 1'b0;
      de_q     <= 1'b0;
      x_q      <= '0;
      bx_q     <= '0;
      ht_q     <= '0;
      hfull_q  <= 1'b0;
      y_q      <= '0;
      by_q     <= '0;
      vt_q     <= '0;
      vfull_q  <= 1'b0;
      err_q    <= 1'b0;
      ht_cur_q <= '0;
      vt_cur_q <= '0;
    end else begin
      state_q  <= state_d;
      vs_q     <= vin_vs_i;
      hs_q     <= vin_hs_i;
      de_q     <= vin_de_i;
      x_q      <= x_d;
      bx_q     <= bx_d;
      ht_q     <= ht_d;
      hfull_q  <= hfull_d;
      y_q      <= y_d;
      by_q     <= by_d;
      vt_q     <= vt_d;
      vfull_q  <= vfull_d;
      err_q    <= err_d;
      ht_cur_q <= ht_cur_d;
      vt_cur_q <= vt_cur_d;
    end
  end

endmodule

// File: rtl/theme_ctrl.sv
// Theme controller: counts light blocks per frame and drives the smoother's
// dark->light / light->dark targets from that count and the user mode.
module theme_ctrl
  import ddf_pkg::*;
#(
  parameter int HBLKS = 10,
  parameter int VBLKS = 10,
  parameter int HRES  = 1920,
  parameter int VRES  = 1080,
  parameter int TH_HI = 60,
  parameter int TH_LO = 40,
  localparam int HT_W  = width_of(HBLKS),
  localparam int VT_W  = width_of(VBLKS),
  localparam int CNT_W = width_of(HBLKS * VBLKS + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             vin_vs_i,
  input  logic             vin_hs_i,
  input  logic             vin_de_i,
  input  logic             blk_i,
  input  logic [1:0]       mode_i,
  output logic [HT_W-1:0]  ht_cur_o,
  output logic [VT_W-1:0]  vt_cur_o,
  output logic             dl_o,
  output logic             ld_o,
  output logic [CNT_W-1:0] light_cnt_o,
  output logic             frame_err_o
);

  logic             origin, vs_rise, frame_close, frame_bad;
  logic             sample;
  logic [CNT_W-1:0] cnt_q, cnt_d, light_cnt_q, light_cnt_d;
  logic             frame_err_q, frame_err_d;
  logic             dl_q, dl_d, ld_q, ld_d;

  blk_locator #(
    .HBLKS(HBLKS),
    .VBLKS(VBLKS),
    .HRES (HRES),
    .VRES (VRES)
  ) u_locator (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .vin_vs_i     (vin_vs_i),
    .vin_hs_i     (vin_hs_i),
    .vin_de_i     (vin_de_i),
    .ht_cur_o     (ht_cur_o),
    .vt_cur_o     (vt_cur_o),
    .origin_o     (origin),
    .vs_rise_o    (vs_rise),
    .frame_close_o(frame_close),
    .frame_bad_o  (frame_bad)
  );

  // Running count (a sample on the vs edge starts the new frame) and the
  // frame-close statistics/theme decision.
  always_comb begin
    sample      = origin & blk_i;
    cnt_d       = vs_rise ? CNT_W'(sample) : cnt_q + CNT_W'(sample);
    light_cnt_d = light_cnt_q;
    frame_err_d = frame_err_q;
    dl_d        = dl_q;
    ld_d        = ld_q;
    if (frame_close) begin
      frame_err_d = frame_bad;
      if (!frame_bad) light_cnt_d = cnt_q;
      case (mode_t'(mode_i))
        MODE_DARK:   begin dl_d = 1'b0; ld_d = 1'b0; end
        MODE_LIGHT:  begin dl_d = 1'b1; ld_d = 1'b1; end
        MODE_BYPASS: begin dl_d = 1'b0; ld_d = 1'b1; end
        MODE_AUTO: begin
          // Between the thresholds (or on a bad frame) the previous theme holds.
          if (!frame_bad && cnt_q >= CNT_W'(TH_HI)) begin
            dl_d = 1'b0; ld_d = 1'b0;
          end else if (!frame_bad && cnt_q <= CNT_W'(TH_LO)) begin
            dl_d = 1'b0; ld_d = 1'b1;
          end
        end
      endcase
    end
  end

  // Accumulator and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      light_cnt_q <= '0;
      frame_err_q <= 1'b0;
      dl_q        <= 1'b0;
      ld_q        <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      light_cnt_q <= light_cnt_d;
      frame_err_q <= frame_err_d;
      dl_q        <= dl_d;
      ld_q        <= ld_d;
    end
  end

  assign light_cnt_o = light_cnt_q;
  assign frame_err_o = frame_err_q;
  assign dl_o        = dl_q;
  assign ld_o        = ld_q;

endmodule

// File: tb/tb_theme_ctrl.sv
// Directed bench for theme_ctrl on a reduced 40x20 raster (4x2-pixel blocks).
module tb_theme_ctrl;

  localparam int HBLKS = 10;
  localparam int VBLKS = 10;
  localparam int HRES  = 40;
  localparam int VRES  = 20;
  localparam int BW    = HRES / HBLKS;
  localparam int BH    = VRES / VBLKS;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       vin_vs_i, vin_hs_i, vin_de_i, blk_i;
  logic [1:0] mode_i;
  logic [3:0] ht_cur_o, vt_cur_o;
  logic       dl_o, ld_o;
  logic [6:0] light_cnt_o;
  logic       frame_err_o;

  int n_tests = 0;
  int n_fail  = 0;

  theme_ctrl #(
    .HBLKS(HBLKS), .VBLKS(VBLKS), .HRES(HRES), .VRES(VRES), .TH_HI(60), .TH_LO(40)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .vin_vs_i   (vin_vs_i),
    .vin_hs_i   (vin_hs_i),
    .vin_de_i   (vin_de_i),
    .blk_i      (blk_i),
    .mode_i     (mode_i),
    .ht_cur_o   (ht_cur_o),
    .vt_cur_o   (vt_cur_o),
    .dl_o       (dl_o),
    .ld_o       (ld_o),
    .light_cnt_o(light_cnt_o),
    .frame_err_o(frame_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One frame of lines; blocks with raster index < nlight are light.
  // short_line gets HRES-1 pixels; mode_i switches at the start of mode_line.
  task automatic send_frame(input int lines, input int short_line, input int nlight,
                            input bit chk, input int mode_line, input logic [1:0] new_mode);
    for (int l = 0; l < lines; l++) begin
      if (l == mode_line) mode_i = new_mode;
      vin_hs_i = 1'b1; tick();
      vin_hs_i = 1'b0; tick(); tick();
      for (int x = 0; x < ((l == short_line) ? HRES - 1 : HRES); x++) begin
        vin_de_i = 1'b1;
        blk_i    = (((l / BH) * HBLKS + x / BW) < nlight);
        tick();
        if (chk && (x % BW == 0)) check($sformatf("ht l%0d x%0d", l, x), ht_cur_o, x / BW);
        if (chk && x == 0)
          check($sformatf("vt l%0d", l), vt_cur_o, (l / BH > VBLKS - 1) ? VBLKS - 1 : l / BH);
      end
      vin_de_i = 1'b0;
      blk_i    = 1'b0;
      tick(); tick();
    end
  endtask

  task automatic vs_edge();
    vin_vs_i = 1'b1;
    tick();
  endtask

  task automatic vs_tail();
    tick();
    vin_vs_i = 1'b0;
    tick(); tick();
  endtask

  task automatic check_out(input string tag, input int cnt, input bit err, input bit dl, input bit ld);
    check({tag, " light_cnt"}, light_cnt_o, cnt);
    check({tag, " frame_err"}, frame_err_o, err);
    check({tag, " dl"}, dl_o, dl);
    check({tag, " ld"}, ld_o, ld);
  endtask

  initial begin
    rst_i = 1'b1;
    vin_vs_i = 1'b0; vin_hs_i = 1'b0; vin_de_i = 1'b0; blk_i = 1'b0;
    mode_i = 2'd3;
    tick(); tick();
    check_out("reset", 0, 1'b0, 1'b0, 1'b0);
    check("reset ht", ht_cur_o, 0);
    check("reset vt", vt_cur_o, 0);
    rst_i = 1'b0;
    tick();

    // Bypass: first edge only arms the tracker, second closes a 30-block frame.
    vs_edge(); vs_tail();
    send_frame(VRES, -1, 30, 1'b0, -1, 2'd3);
    vs_edge();
    check_out("bypass frame", 30, 1'b0, 1'b0, 1'b1);
    vs_tail();

    // Asynchronous reset mid-line of a partial frame.
    send_frame(10, -1, 100, 1'b0, -1, 2'd3);
    vin_de_i = 1'b1; blk_i = 1'b1;
    tick(); tick();
    check("pre-reset vt", vt_cur_o, 5);
    #2;
    rst_i = 1'b1; vin_de_i = 1'b0; blk_i = 1'b0;
    #1;
    check_out("mid-frame reset", 0, 1'b0, 1'b0, 1'b0);
    check("mid-frame reset vt", vt_cur_o, 0);
    tick();
    rst_i  = 1'b0;
    mode_i = 2'd0;

    // Partial frame after reset is never reported.
    send_frame(6, -1, 100, 1'b0, -1, 2'd0);
    vs_edge();
    check_out("first edge after reset", 0, 1'b0, 1'b0, 1'b0);
    vs_tail();
    send_frame(VRES, -1, 100, 1'b0, -1, 2'd0);
    vs_edge();
    check_out("auto 100", 100, 1'b0, 1'b0, 1'b0);
    vs_tail();

    // Hysteresis: 50 holds dark, 30 selects passthrough.
    send_frame(VRES, -1, 50, 1'b0, -1, 2'd0);
    vs_edge();
    check_out("auto 50 hold", 50, 1'b0, 1'b0, 1'b0);
    vs_tail();
    send_frame(VRES, -1, 30, 1'b0, -1, 2'd0);
    vs_edge();
    check_out("auto 30", 30, 1'b0, 1'b0, 1'b1);
    vs_tail();

    // Short line: statistics discarded, theme held; next good frame clears the error.
    send_frame(VRES, 5, 100, 1'b0, -1, 2'd0);
    vs_edge();
    check_out("short line", 30, 1'b1, 1'b0, 1'b1);
    vs_tail();
    send_frame(VRES, -1, 45, 1'b0, -1, 2'd0);
    vs_edge();
    check_out("recover", 45, 1'b0, 1'b0, 1'b1);
    vs_tail();

    // Mode change mid-frame takes effect only at the next vs edge, one cycle later.
    send_frame(VRES, -1, 45, 1'b0, 10, 2'd2);
    check("mode mid-frame dl", dl_o, 0);
    check("mode mid-frame ld", ld_o, 1);
    vin_vs_i = 1'b1;
    @(posedge clk_i);
    #0;
    check("mode pre-edge dl", dl_o, 0);
    #1;
    check_out("mode light", 45, 1'b0, 1'b1, 1'b1);
    vs_tail();
    mode_i = 2'd3;
    send_frame(VRES, -1, 45, 1'b0, -1, 2'd3);
    vs_edge();
    check_out("mode bypass", 45, 1'b0, 1'b0, 1'b1);
    vs_tail();

    // Raster scan with coordinate checks, auto mode.
    mode_i = 2'd0;
    send_frame(VRES, -1, 100, 1'b1, -1, 2'd0);
    vs_edge();
    check_out("raster", 100, 1'b0, 1'b0, 0);
    vs_tail();

    // One line too many: error, vt saturates, count and theme held.
    send_frame(VRES + 1, -1, 100, 1'b1, -1, 2'd0);
    vs_edge();
    check_out("tall frame", 100, 1'b1, 1'b0, 1'b0);
    vs_tail();
    send_frame(VRES, -1, 20, 1'b0, -1, 2'd0);
    vs_edge();
    check_out("after tall", 20, 1'b0, 1'b0, 1'b1);
    vs_tail();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
